// File: rtl/serdesphy_seq_pkg.sv
// Shared definitions for the SerDes PHY link sequencer: state encoding and
// default timing constants for a 24 MHz system clock.
package serdesphy_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_PLL_RST  = 3'd2,
        ST_PLL_LOCK = 3'd3,
        ST_CDR_RST  = 3'd4,
        ST_CDR_LOCK = 3'd5,
        ST_READY    = 3'd6,
        ST_FAULT    = 3'd7
    } seq_state_e;

    localparam int DEF_PWR_SETTLE_CYCLES = 48;
    localparam int DEF_PLL_RST_CYCLES    = 24;
    localparam int DEF_CDR_RST_CYCLES    = 24;
    localparam int DEF_LOCK_FILTER       = 8;
    localparam int DEF_LOCK_TIMEOUT      = 24000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// Consecutive-high qualifier for a raw analog lock indication. 'qualified' is a
// look-ahead: it asserts in the cycle the FILTER_LEN-th consecutive high is seen.
module serdesphy_lock_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic lock_in,
    output logic qualified
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] RUN_SAT  = CW'(FILTER_LEN);
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (clr || !lock_in) begin
            run_cnt <= '0;
        end else if (run_cnt != RUN_SAT) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

    assign qualified = lock_in && !clr && (run_cnt >= RUN_LAST);

endmodule

// File: rtl/serdesphy_link_sequencer.sv
// PHY bring-up sequencer: OFF -> power settle -> PLL reset/lock -> CDR reset/lock -> READY.
// Optional macro SERDESPHY_LOCK_TIMEOUT_EN enables lock-wait timeouts and the FAULT state.
module serdesphy_link_sequencer
    import serdesphy_seq_pkg::*;
#(
    parameter int PWR_SETTLE_CYCLES = DEF_PWR_SETTLE_CYCLES,
    parameter int PLL_RST_CYCLES    = DEF_PLL_RST_CYCLES,
    parameter int CDR_RST_CYCLES    = DEF_CDR_RST_CYCLES,
    parameter int LOCK_FILTER       = DEF_LOCK_FILTER,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phy_en,
    input  logic       power_good,
    input  logic       pll_bypass,
    input  logic       pll_rst_req,
    input  logic       cdr_rst_req,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    output logic       ana_iso,
    output logic       pll_rst_out,
    output logic       cdr_rst_out,
    output logic       por_active,
    output logic       por_complete,
    output logic       pll_ready,
    output logic       phy_ready,
    output logic       pll_error,
    output logic [2:0] seq_state
);

    localparam int CNT_MAX_PARAM = max_int(max_int(max_int(PWR_SETTLE_CYCLES, PLL_RST_CYCLES),
                                                   max_int(CDR_RST_CYCLES, LOCK_FILTER)),
                                           LOCK_TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX_PARAM) + 1;

    // Dwell comparisons fire on the last cycle of occupancy so the state lasts exactly N cycles
    localparam logic [CNT_W-1:0] PWR_LAST     = CNT_W'(PWR_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CDR_RST_LAST = CNT_W'(CDR_RST_CYCLES - 1);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic             pll_ready_q;
    logic             ready_set;
    logic             ready_clr;
    logic             pll_qual;
    logic             cdr_qual;
    logic             timeout_hit;
    logic             pll_filt_clr;
    logic             cdr_filt_clr;

    assign pll_filt_clr = (state != ST_PLL_LOCK);
    assign cdr_filt_clr = (state != ST_CDR_LOCK);

    serdesphy_lock_filter #(
        .FILTER_LEN (LOCK_FILTER)
    ) u_pll_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pll_filt_clr),
        .lock_in   (pll_lock),
        .qualified (pll_qual)
    );

    serdesphy_lock_filter #(
        .FILTER_LEN (LOCK_FILTER)
    ) u_cdr_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cdr_filt_clr),
        .lock_in   (cdr_lock),
        .qualified (cdr_qual)
    );

`ifdef SERDESPHY_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    assign timeout_hit = (dwell_cnt >= TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            dwell_cnt   <= '0;
            pll_ready_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                dwell_cnt <= '0;
            end else if (dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
            if (ready_clr) begin
                pll_ready_q <= 1'b0;
            end else if (ready_set) begin
                pll_ready_q <= 1'b1;
            end
        end
    end

    // Global overrides first, then software resets, then per-state progress
    always_comb begin
        state_nxt = state;
        ready_set = 1'b0;
        ready_clr = 1'b0;

        if (!phy_en || !power_good) begin
            state_nxt = ST_OFF;
        end else if (pll_rst_req && (state >= ST_PLL_LOCK) && (state <= ST_READY)) begin
            state_nxt = ST_PLL_RST;
        end else if (cdr_rst_req && (state == ST_CDR_LOCK || state == ST_READY)) begin
            state_nxt = ST_CDR_RST;
        end else begin
            case (state)
                ST_OFF:      state_nxt = ST_PWR_WAIT;
                ST_PWR_WAIT: if (dwell_cnt >= PWR_LAST) state_nxt = ST_PLL_RST;
                ST_PLL_RST: begin
                    if (dwell_cnt >= PLL_RST_LAST) begin
                        state_nxt = pll_bypass ? ST_CDR_RST : ST_PLL_LOCK;
                    end
                end
                ST_PLL_LOCK: begin
                    if (pll_qual) begin
                        state_nxt = ST_CDR_RST;
                    end else if (timeout_hit) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_CDR_RST:  if (dwell_cnt >= CDR_RST_LAST) state_nxt = ST_CDR_LOCK;
                ST_CDR_LOCK: begin
                    if (cdr_qual) begin
                        state_nxt = ST_READY;
                    end else if (timeout_hit) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_READY: begin
                    if (!pll_lock && !pll_bypass) begin
                        state_nxt = ST_PLL_RST;
                    end else if (!cdr_lock) begin
                        state_nxt = ST_CDR_RST;
                    end
                end
                ST_FAULT:    state_nxt = ST_FAULT;
            endcase
        end

        ready_clr = (state_nxt == ST_OFF) || (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
        ready_set = (state_nxt == ST_CDR_RST) &&
                    ((state == ST_PLL_LOCK) || (state == ST_PLL_RST));
    end

    assign ana_iso      = (state == ST_OFF) || (state == ST_PWR_WAIT);
    assign pll_rst_out  = (state <= ST_PLL_RST);
    assign cdr_rst_out  = (state <= ST_CDR_RST) || (state == ST_FAULT);
    assign por_active   = (state >= ST_PWR_WAIT) && (state <= ST_CDR_LOCK);
    assign por_complete = (state == ST_READY);
    assign phy_ready    = (state == ST_READY);
    assign pll_ready    = pll_ready_q;
    assign seq_state    = state;

`ifdef SERDESPHY_LOCK_TIMEOUT_EN
    assign pll_error = (state == ST_FAULT);
`else
    assign pll_error = 1'b0;
`endif

endmodule
